// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one
// input bit per clock. Feeds the multiplexed 7-segment display stage with one
// decimal digit per nibble. Values above the display range saturate to all 9s
// and raise ovf.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active low
//   start  - conversion request, sampled only while idle
//   bin    - binary input, captured on the edge that accepts start
//   bcd    - registered packed BCD result, digit 0 in [3:0]
//   ovf    - registered flag, last captured value exceeded 10**DIGITS-1
//   busy   - high whenever a conversion is in flight
//   done   - one-cycle pulse when bcd/ovf take a new result
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 4,
    parameter int CNT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    // 10**DIGITS < 2**(4*DIGITS), so this width holds both the limit and bin.
    localparam int CMP_W = ((BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W) + 1;

    function automatic logic [CMP_W-1:0] max_decimal();
        logic [CMP_W-1:0] v;
        v = CMP_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            v = v * CMP_W'(10);
        end
        return v - CMP_W'(1);
    endfunction

    localparam logic [CMP_W-1:0]     MAX_DEC  = max_decimal();
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [BIN_WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]       scratch_q;
    logic [BCD_W-1:0]       scratch_adj;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   ovf_next_q;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults first so every path assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // ---------------------------------------------------------- add-3 stage
    // Each digit >= 5 is corrected before the shift so it carries correctly
    // into the next decimal digit. Arithmetic stays within the nibble.
    always_comb begin
        scratch_adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q    <= bin;
                        scratch_q  <= '0;
                        cnt_q      <= '0;
                        ovf_next_q <= (CMP_W'(bin) > MAX_DEC);
                    end
                end
                CONV: begin
                    // One combined left shift; the MSB of the top digit falls off.
                    {scratch_q, shift_q} <= {scratch_adj, shift_q} << 1;
                    cnt_q                <= cnt_q + CNT_WIDTH'(1);
                end
                DONE: begin
                    bcd  <= ovf_next_q ? {DIGITS{4'h9}} : scratch_q;
                    ovf  <= ovf_next_q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Directed self-checking bench for bin_to_bcd_seq with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic [15:0] bcd;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One conversion with a one-cycle start pulse. Negedge k follows edge Ek,
    // where E0 is the accepting edge: busy is expected at k=0..16, done at k=17.
    task automatic convert(input string tag, input logic [15:0] v,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int          busy_cnt;
        int          lat;
        logic        hold_ok;
        logic [15:0] prev;
        busy_cnt = 0;
        lat      = -1;
        hold_ok  = 1'b1;
        @(negedge clk);
        prev  = bcd;
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'hdead;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) lat = k;
            else if (bcd !== prev) hold_ok = 1'b0;
        end
        check($sformatf("%s_latency", tag), lat, 17);
        check($sformatf("%s_busy_cycles", tag), busy_cnt, 17);
        check($sformatf("%s_hold", tag), {31'd0, hold_ok}, 1);
        check($sformatf("%s_bcd", tag), {16'd0, bcd}, {16'd0, exp_bcd});
        check($sformatf("%s_ovf", tag), {31'd0, ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        check($sformatf("%s_done_single", tag), {31'd0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int first_k;
        int last_k;
        int gap_bad;
        int bcd_bad;
        int waited;

        // ------------------------------------------------------------ reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bcd",  {16'd0, bcd}, 0);
        check("reset_ovf",  {31'd0, ovf}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        // --------------------------------------------------- basic values
        convert("c1234", 16'd1234, 16'h1234, 1'b0);
        convert("c0",    16'd0,    16'h0000, 1'b0);
        convert("c9999", 16'd9999, 16'h9999, 1'b0);

        // ------------------------------------------------------ saturation
        convert("c10000", 16'd10000, 16'h9999, 1'b1);
        convert("c65535", 16'd65535, 16'h9999, 1'b1);
        convert("c42",    16'd42,    16'h0042, 1'b0);

        // ----------------------------------------- start ignored while busy
        @(negedge clk);
        bin   = 16'd500;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (done) done_cnt++;
            if (k == 3 || k == 16) begin
                start = 1'b1;
                bin   = 16'd777;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_done_count", done_cnt, 1);
        check("ignore_bcd", {16'd0, bcd}, 32'h0500);
        check("ignore_busy", {31'd0, busy}, 0);

        // ------------------------------------------------ start held high
        @(negedge clk);
        bin   = 16'd88;
        start = 1'b1;
        @(negedge clk);
        done_cnt = 0;
        first_k  = -1;
        last_k   = -1;
        gap_bad  = 0;
        bcd_bad  = 0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_k < 0) first_k = k;
                else if (k - last_k != 18) gap_bad++;
                last_k = k;
                if (bcd !== 16'h0088) bcd_bad++;
            end
        end
        start = 1'b0;
        check("held_first_done", first_k, 17);
        check("held_done_count", done_cnt, 3);
        check("held_spacing_errors", gap_bad, 0);
        check("held_bcd_errors", bcd_bad, 0);
        waited = 0;
        while (busy && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("held_drain", {31'd0, busy}, 0);

        // ---------------------------------------------- mid-conversion reset
        @(negedge clk);
        bin   = 16'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_bcd",  {16'd0, bcd}, 0);
        check("abort_done", {31'd0, done}, 0);
        rst      = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_no_activity", done_cnt, 0);
        convert("c17", 16'd17, 16'h0017, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
